seq_divider: RTL and testbench

Parametrised multi-cycle restoring divider with integrated control. It computes quotient and remainder one bit per cycle, supports signed and unsigned operands, and flags divide-by-zero and signed overflow. It is the WIDTH-generic successor to the fixed 32-bit division control FSM and sits beside the ALU as the divide unit.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 163 ++++++++++++++++
 tb/tb_seq_divider.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } div_state_e;

  // Bit replicated across the quotient when the divisor is zero.
  localparam logic DIV0_QUO_FILL = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract, restore on borrow.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    qbit_o  = ~diff[WIDTH];
    // A non-borrowing difference is always below the divisor, so WIDTH bits suffice.
    rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], qbit_o};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with divide-by-zero and overflow flags.
import div_pkg::*;

module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             ovf
);

  localparam int unsigned     CW      = clog2(WIDTH);
  localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] babs_q, babs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (babs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo),
    .qbit_o    (step_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      babs_q      <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      babs_q      <= babs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    babs_d      = babs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          sgn_d   = signed_mode;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Magnitudes are plain unsigned negations, so |MIN| lands on 2^(WIDTH-1).
        rem_d   = '0;
        quo_d   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        babs_d  = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        qneg_d  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d  = sgn_q & a_q[WIDTH-1];
        cnt_d   = '0;
        state_d = (b_q == '0) ? FIXUP : ITER;
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIXUP;
      end
      FIXUP: begin
        if (b_q == '0) begin
          quotient_d  = {WIDTH{DIV0_QUO_FILL}};
          remainder_d = a_q;
          div_zero_d  = 1'b1;
          ovf_d       = 1'b0;
        end else if (sgn_q && (a_q == MIN_VAL) && (b_q == '1)) begin
          quotient_d  = MIN_VAL;
          remainder_d = '0;
          div_zero_d  = 1'b0;
          ovf_d       = 1'b1;
        end else begin
          quotient_d  = qneg_q ? -quo_q : quo_q;
          remainder_d = rneg_q ? -rem_q : rem_q;
          div_zero_d  = 1'b0;
          ovf_d       = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider at WIDTH=32 and WIDTH=8.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        st32, sm32, busy32, done32, dz32, ov32;
  logic [31:0] dd32, dv32, q32, r32;
  logic        st8, sm8, busy8, done8, dz8, ov8;
  logic [7:0]  dd8, dv8, q8, r8;

  int checks;
  int passed;

  seq_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(st32), .signed_mode(sm32),
    .dividend(dd32), .divisor(dv32), .busy(busy32), .done(done32),
    .quotient(q32), .remainder(r32), .div_zero(dz32), .ovf(ov32)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(sm8),
    .dividend(dd8), .divisor(dv8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_zero(dz8), .ovf(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one start pulse; returns at the falling edge after E0.
  task automatic start_op(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (w8) begin
      st8 = 1'b1; sm8 = sgn; dd8 = a[7:0]; dv8 = b[7:0];
    end else begin
      st32 = 1'b1; sm32 = sgn; dd32 = a; dv32 = b;
    end
    @(negedge clk);
    st8  = 1'b0;
    st32 = 1'b0;
  endtask

  // Latency is k where done is first seen after edge Ek; -1 on timeout.
  task automatic wait_done(input bit w8, output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if ((w8 ? busy8 : busy32) !== 1'b1) busy_ok = 1'b0;
      if ((w8 ? done8 : done32) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy32, done32, q32, r32, dz32, ov32} !== 68'd0)
      $display("FAIL reset32 got busy=%b done=%b q=%h r=%h dz=%b ovf=%b want all 0", busy32, done32, q32, r32, dz32, ov32);
    else passed++;
    checks++;
    if ({busy8, done8, q8, r8, dz8, ov8} !== 20'd0)
      $display("FAIL reset8 got busy=%b done=%b q=%h r=%h dz=%b ovf=%b want all 0", busy8, done8, q8, r8, dz8, ov8);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat;
    bit bok;
    start_op(1'b0, 1'b0, 32'd100, 32'd7);
    wait_done(1'b0, lat, bok);
    checks++;
    if (lat !== 34) $display("FAIL u100_7_latency got %0d want 34", lat); else passed++;
    checks++;
    if (bok !== 1'b1) $display("FAIL u100_7_busy got low-before-done want busy=1 through DONE"); else passed++;
    checks++;
    if (q32 !== 32'd14 || r32 !== 32'd2) $display("FAIL u100_7_result got q=%0d r=%0d want q=14 r=2", q32, r32); else passed++;
    checks++;
    if (dz32 !== 1'b0 || ov32 !== 1'b0) $display("FAIL u100_7_flags got dz=%b ovf=%b want 0 0", dz32, ov32); else passed++;
    @(negedge clk);
    checks++;
    if (done32 !== 1'b0 || busy32 !== 1'b0) $display("FAIL u100_7_after got done=%b busy=%b want 0 0", done32, busy32); else passed++;
  endtask

  task automatic test_signed;
    int lat;
    bit bok;
    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(1'b0, lat, bok);
    checks++;
    if (q32 !== 32'hFFFF_FFFD || r32 !== 32'hFFFF_FFFF || lat !== 34)
      $display("FAIL s_m7_2 got q=%h r=%h lat=%0d want q=fffffffd r=ffffffff lat=34", q32, r32, lat);
    else passed++;
    start_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(1'b0, lat, bok);
    checks++;
    if (q32 !== 32'hFFFF_FFFD || r32 !== 32'd1)
      $display("FAIL s_7_m2 got q=%h r=%h want q=fffffffd r=00000001", q32, r32);
    else passed++;
  endtask

  task automatic test_div_zero;
    int lat;
    bit bok;
    for (int m = 0; m < 2; m++) begin
      start_op(1'b0, m[0], 32'd5, 32'd0);
      wait_done(1'b0, lat, bok);
      checks++;
      if (q32 !== 32'hFFFF_FFFF || r32 !== 32'd5 || dz32 !== 1'b1 || ov32 !== 1'b0 || lat !== 2)
        $display("FAIL div0_mode%0d got q=%h r=%h dz=%b ovf=%b lat=%0d want q=ffffffff r=5 dz=1 ovf=0 lat=2", m, q32, r32, dz32, ov32, lat);
      else passed++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dz32 !== 1'b1 || q32 !== 32'hFFFF_FFFF) $display("FAIL div0_hold got dz=%b q=%h want 1 ffffffff", dz32, q32); else passed++;
  endtask

  task automatic test_overflow;
    int lat;
    bit bok;
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, lat, bok);
    checks++;
    if (q32 !== 32'h8000_0000 || r32 !== 32'd0 || ov32 !== 1'b1 || dz32 !== 1'b0 || lat !== 34)
      $display("FAIL ovf_signed got q=%h r=%h ovf=%b dz=%b lat=%0d want q=80000000 r=0 ovf=1 dz=0 lat=34", q32, r32, ov32, dz32, lat);
    else passed++;
    start_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, lat, bok);
    checks++;
    if (q32 !== 32'd0 || r32 !== 32'h8000_0000 || ov32 !== 1'b0)
      $display("FAIL ovf_unsigned got q=%h r=%h ovf=%b want q=0 r=80000000 ovf=0", q32, r32, ov32);
    else passed++;
  endtask

  task automatic test_start_ignored;
    int lat;
    bit seen;
    start_op(1'b0, 1'b0, 32'd100, 32'd7);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done32 === 1'b1) begin
        lat = k;
        break;
      end
      st32 = (k == 5 || k == 12 || k == 20);
      dd32 = 32'd9;
      dv32 = 32'd3;
    end
    st32 = 1'b0;
    checks++;
    if (q32 !== 32'd14 || r32 !== 32'd2 || lat !== 34)
      $display("FAIL start_in_iter got q=%0d r=%0d lat=%0d want q=14 r=2 lat=34", q32, r32, lat);
    else passed++;
    // Start raised only across the DONE-cycle edge must not launch an operation.
    st32 = 1'b1;
    @(negedge clk);
    st32 = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy32 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL start_in_done got busy=1 want busy=0"); else passed++;
  endtask

  task automatic test_abort;
    int lat;
    bit bok;
    bit seen;
    start_op(1'b0, 1'b0, 32'd100, 32'd7);
    wait_done(1'b0, lat, bok);
    start_op(1'b0, 1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    checks++;
    if (busy32 !== 1'b1) $display("FAIL abort_pre got busy=%b want 1", busy32); else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy32, done32, q32, r32, dz32, ov32} !== 68'd0)
      $display("FAIL abort_clear got busy=%b done=%b q=%h r=%h dz=%b ovf=%b want all 0", busy32, done32, q32, r32, dz32, ov32);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done32 !== 1'b0 || busy32 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL abort_no_done got activity after reset want none"); else passed++;
  endtask

  task automatic test_width8;
    int lat;
    bit bok;
    start_op(1'b1, 1'b0, 32'd255, 32'd1);
    wait_done(1'b1, lat, bok);
    checks++;
    if (q8 !== 8'd255 || r8 !== 8'd0 || lat !== 10)
      $display("FAIL w8_255_1 got q=%0d r=%0d lat=%0d want q=255 r=0 lat=10", q8, r8, lat);
    else passed++;
    start_op(1'b1, 1'b0, 32'd3, 32'd200);
    wait_done(1'b1, lat, bok);
    checks++;
    if (q8 !== 8'd0 || r8 !== 8'd3 || lat !== 10)
      $display("FAIL w8_3_200 got q=%0d r=%0d lat=%0d want q=0 r=3 lat=10", q8, r8, lat);
    else passed++;
    checks++;
    if (bok !== 1'b1) $display("FAIL w8_busy got low-before-done want busy=1"); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst  = 1'b1;
    st32 = 1'b0; sm32 = 1'b0; dd32 = '0; dv32 = '0;
    st8  = 1'b0; sm8  = 1'b0; dd8  = '0; dv8  = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_start_ignored();
    test_abort();
    test_width8();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
